// File: rtl/key_pkg.sv
// key_pkg -- shared constants for the panel key front-end.
//
// Contents:
//   KEY_LEFT .. KEY_QUIT     bit index of each panel key on the key buses
//   NUM_PANEL_KEYS           number of physical panel keys
//   DEF_*                    default timing constants for a 50 MHz clock
//   max_int()                helper for sizing shared counters
package key_pkg;

  localparam int KEY_LEFT    = 0;
  localparam int KEY_RIGHT   = 1;
  localparam int KEY_UP      = 2;
  localparam int KEY_DOWN    = 3;
  localparam int KEY_CONFIRM = 4;
  localparam int KEY_QUIT    = 5;

  localparam int NUM_PANEL_KEYS = 6;

  // 20 us debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz.
  localparam int DEF_DEBOUNCE_CYC = 1000;
  localparam int DEF_REPEAT_DELAY = 25_000_000;
  localparam int DEF_REPEAT_RATE  = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch -- one key channel: 2-flop synchroniser, debounce counter
// and press/release edge detection on the debounced state.
//
// Ports:
//   clk_50M     system clock
//   rst_n       synchronous active-low reset
//   key_in_raw  raw asynchronous pin, 0 = pressed
//   level       debounced state, 1 = pressed
//   press       1-cycle pulse when the debounced state goes to pressed
//   rel_pulse   1-cycle pulse when the debounced state goes to released
//
// The stable state only flips after the synchronised sample has disagreed
// with it for DEBOUNCE_CYC consecutive cycles, so shorter glitches vanish.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic key_in_raw,
  output logic level,
  output logic press,
  output logic rel_pulse
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;   // 1 = released, matches pin polarity
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    sync1_d  = key_in_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;

    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      press_d  = stable_q;    // leaving released (1) -> pressed
      rel_d    = ~stable_q;   // leaving pressed (0) -> released
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level     = ~stable_q;
  assign press     = press_q;
  assign rel_pulse = rel_q;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen -- panel key front-end: per-key debounce, arbitrated
// one-hot navigation events and optional auto-repeat on a held key.
//
// Ports:
//   clk_50M    system clock
//   rst_n      synchronous active-low reset
//   key_in     raw key pins, 0 = pressed
//   key_level  debounced key state, 1 = pressed
//   key_press  1-cycle pulse per key on debounced press
//   key_evt    one-hot event pulse (release or repeat), at most one bit/cycle
//   key_long   a single key has been held past REPEAT_DELAY
//
// Build option: define KEY_AUTOREPEAT_EN to include the repeat engine.
// Without it every release yields one event and key_long is tied low.
//
// Event pipeline: source (release pulse or repeat tick) -> pend_q on the next
// edge -> key_evt on the following edge, lowest pending index first.
module key_event_gen
  import key_pkg::*;
#(
  parameter int N_KEYS       = NUM_PANEL_KEYS,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_evt,
  output logic              key_long
);

  localparam logic [N_KEYS-1:0] ONE_K = N_KEYS'(1);

  logic [N_KEYS-1:0] rel_w;   // debounced release pulses
  logic [N_KEYS-1:0] src;     // event sources feeding the pending register

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk_50M   (clk_50M),
      .rst_n     (rst_n),
      .key_in_raw(key_in[i]),
      .level     (key_level[i]),
      .press     (key_press[i]),
      .rel_pulse (rel_w[i])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int                RPT_W   = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [RPT_W-1:0] DELAY_T = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RATE_T  = RPT_W'(REPEAT_RATE);
  localparam logic [RPT_W-1:0] ONE_R   = RPT_W'(1);

  // rpt_cnt_q counts edges the current single key has been held (1 on the
  // first edge it is seen), so the tick lands REPEAT_DELAY cycles after
  // key_level rose and is still qualified by the key being held.
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic [N_KEYS-1:0] act_q, act_d;            // key being timed, 0 = none
  logic [N_KEYS-1:0] rep_seen_q, rep_seen_d;  // key has repeated since press
  logic              long_q, long_d;
  logic              single;
  logic              tick;
  logic [N_KEYS-1:0] tick_vec;

  always_comb begin
    single    = (key_level != '0) && ((key_level & (key_level - ONE_K)) == '0);
    tick      = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    act_d     = act_q;
    long_d    = long_q;

    if (!single) begin
      rpt_cnt_d = '0;
      act_d     = '0;
      long_d    = 1'b0;
    end else if (key_level != act_q) begin
      // New single key (fresh press or hand-over from another key).
      rpt_cnt_d = ONE_R;
      act_d     = key_level;
      long_d    = 1'b0;
    end else if (rpt_cnt_q == (long_q ? RATE_T : DELAY_T)) begin
      tick      = 1'b1;
      rpt_cnt_d = ONE_R;
      long_d    = 1'b1;
    end else begin
      rpt_cnt_d = rpt_cnt_q + ONE_R;
    end

    tick_vec   = tick ? key_level : '0;
    // A press re-arms the release event; a repeat swallows it.
    rep_seen_d = (rep_seen_q & ~key_press) | tick_vec;
    src        = (rel_w & ~rep_seen_q) | tick_vec;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      rpt_cnt_q  <= '0;
      act_q      <= '0;
      rep_seen_q <= '0;
      long_q     <= 1'b0;
    end else begin
      rpt_cnt_q  <= rpt_cnt_d;
      act_q      <= act_d;
      rep_seen_q <= rep_seen_d;
      long_q     <= long_d;
    end
  end

  assign key_long = long_q;
`else
  logic [31:0] unused_repeat_cfg;

  assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_RATE;
  assign src               = rel_w;
  assign key_long          = 1'b0;
`endif

  // Fixed-priority arbiter: lowest pending index wins; sources arriving for
  // an already-pending key merge into the same pending bit.
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [N_KEYS-1:0] evt_q, evt_d;
  logic [N_KEYS-1:0] grant;

  always_comb begin
    grant  = pend_q & (~pend_q + ONE_K);
    evt_d  = grant;
    pend_d = (pend_q & ~grant) | src;
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      pend_q <= '0;
      evt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      evt_q  <= evt_d;
    end
  end

  assign key_evt = evt_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Testbench for key_event_gen with DEBOUNCE_CYC=8, REPEAT_DELAY=100,
// REPEAT_RATE=20. Inputs change and outputs are sampled 1 time unit after
// each rising edge; cyc counts rising edges since time 0.
module tb_key_event_gen;
  import key_pkg::*;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic [5:0] key_in;
  logic [5:0] key_level;
  logic [5:0] key_press;
  logic [5:0] key_evt;
  logic       key_long;

  always #10 clk_50M = ~clk_50M;

  key_event_gen #(
    .N_KEYS      (6),
    .DEBOUNCE_CYC(8),
    .REPEAT_DELAY(100),
    .REPEAT_RATE (20)
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_level(key_level),
    .key_press(key_press),
    .key_evt  (key_evt),
    .key_long (key_long)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_long   = 0;
  int n_press  = 0;
  int n_lvl    = 0;

  typedef struct {
    int         cyc;
    logic [5:0] evt;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    string      name;
    logic [5:0] keys;
    int         steps;
    logic [5:0] lvl;
    logic [5:0] press;
    logic [5:0] evt;
  } seg_t;
  seg_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50M);
      #1;
      cyc++;
      if (key_evt != 6'd0) begin
        evq.push_back('{cyc, key_evt});
        check("evt_onehot", $countones(key_evt), 1);
      end
      if (key_long === 1'b1) n_long++;
      if (key_press != 6'd0) n_press++;
      if (key_level != 6'd0) n_lvl++;
    end
  endtask

  task automatic clear_log();
    evq.delete();
    n_long  = 0;
    n_press = 0;
    n_lvl   = 0;
  endtask

  task automatic run_row(input int i);
    key_in = tbl[i].keys;
    step(tbl[i].steps);
    check({tbl[i].name, "/level"}, key_level, tbl[i].lvl);
    check({tbl[i].name, "/press"}, key_press, tbl[i].press);
    check({tbl[i].name, "/evt"},   key_evt,   tbl[i].evt);
    check({tbl[i].name, "/long"},  key_long,  1'b0);
  endtask

  initial begin
    int t_l;
    int t_r;

    // Step counts are relative to the previous row; key edges are applied
    // at the start of a row. Level/press lag a raw edge by 10 cycles, a
    // release event by 12.
    tbl.push_back('{"glitch_low",   6'b111110,  4, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"glitch_after", 6'b111111, 16, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_pre",       6'b101111,  9, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_press",     6'b101111,  1, 6'b010000, 6'b010000, 6'b000000});
    tbl.push_back('{"k4_press_end", 6'b101111,  1, 6'b010000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_hold",      6'b101111, 39, 6'b010000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_rel_pre",   6'b111111,  9, 6'b010000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_rel_lvl",   6'b111111,  1, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_pend",      6'b111111,  1, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k4_evt",       6'b111111,  1, 6'b000000, 6'b000000, 6'b010000});
    tbl.push_back('{"k4_evt_end",   6'b111111,  1, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k13_pre",      6'b110101,  9, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k13_press",    6'b110101,  1, 6'b001010, 6'b001010, 6'b000000});
    tbl.push_back('{"k13_hold",     6'b110101, 10, 6'b001010, 6'b000000, 6'b000000});
    tbl.push_back('{"k13_rel_pend", 6'b111111, 11, 6'b000000, 6'b000000, 6'b000000});
    tbl.push_back('{"k13_evt1",     6'b111111,  1, 6'b000000, 6'b000000, 6'b000010});
    tbl.push_back('{"k13_evt2",     6'b111111,  1, 6'b000000, 6'b000000, 6'b001000});
    tbl.push_back('{"k13_idle",     6'b111111, 10, 6'b000000, 6'b000000, 6'b000000});

    // Reset dominates even with every key pressed.
    rst_n  = 1'b0;
    key_in = 6'b000000;
    step(3);
    check("rst_level", key_level, 6'b000000);
    check("rst_press", key_press, 6'b000000);
    check("rst_evt",   key_evt,   6'b000000);
    check("rst_long",  key_long,  1'b0);
    key_in = 6'b111111;
    step(2);
    rst_n = 1'b1;
    step(5);
    check("post_rst_level", key_level, 6'b000000);

    // Glitch shorter than the debounce window: nothing at all happens.
    clear_log();
    for (int i = 0; i < 2; i++) run_row(i);
    check("glitch_lvl_cycles", n_lvl, 0);
    check("glitch_press_cnt",  n_press, 0);
    check("glitch_evt_cnt",    evq.size(), 0);

    // Single release, then two simultaneous releases.
    clear_log();
    for (int i = 2; i < tbl.size(); i++) run_row(i);
    check("tbl_evt_cnt", evq.size(), 3);
    if (evq.size() == 3) begin
      check("tbl_evt0", evq[0].evt, 6'b010000);
      check("tbl_evt1", evq[1].evt, 6'b000010);
      check("tbl_evt2", evq[2].evt, 6'b001000);
      check("tbl_evt12_gap", evq[2].cyc - evq[1].cyc, 1);
    end

    // Key 2 held 200 cycles.
    clear_log();
    key_in = 6'b111011;
    step(10);
    check("k2_level", key_level, 6'b000100);
    check("k2_press", key_press, 6'b000100);
    t_l = cyc;
    step(100);
    check("k2_long_pre", key_long, 1'b0);
    step(1);
`ifdef KEY_AUTOREPEAT_EN
    check("k2_long_set", key_long, 1'b1);
`else
    check("k2_long_set", key_long, 1'b0);
`endif
    step(89);
    key_in = 6'b111111;
    step(20);
    check("k2_level_end", key_level, 6'b000000);
    check("k2_long_end",  key_long,  1'b0);
`ifdef KEY_AUTOREPEAT_EN
    // Ticks at 100,120,..,180 after the level rose; events 2 cycles later.
    check("k2_rep_cnt", evq.size(), 5);
    for (int k = 0; k < evq.size() && k < 5; k++) begin
      check("k2_rep_cyc", evq[k].cyc - t_l, 102 + 20 * k);
      check("k2_rep_evt", evq[k].evt, 6'b000100);
    end
`else
    check("k2_evt_cnt", evq.size(), 1);
    if (evq.size() >= 1) begin
      check("k2_rel_cyc", evq[0].cyc - t_l, 190 + 12);
      check("k2_rel_evt", evq[0].evt, 6'b000100);
    end
    check("k2_long_cycles", n_long, 0);
`endif

    // Keys 0 and 1 held together: never a single key, so no repeats.
    clear_log();
    key_in = 6'b111100;
    step(200);
    check("k01_level", key_level, 6'b000011);
    check("k01_long_cycles", n_long, 0);
    check("k01_hold_evts", evq.size(), 0);
    t_r = cyc;
    key_in = 6'b111111;
    step(20);
    check("k01_evt_cnt", evq.size(), 2);
    if (evq.size() == 2) begin
      check("k01_evt0_cyc", evq[0].cyc - t_r, 12);
      check("k01_evt0",     evq[0].evt, 6'b000001);
      check("k01_evt1_cyc", evq[1].cyc - t_r, 13);
      check("k01_evt1",     evq[1].evt, 6'b000010);
    end

    // Reset in the middle of a key 5 hold.
    clear_log();
    key_in = 6'b011111;
    step(60);
    check("k5_level", key_level, 6'b100000);
    rst_n = 1'b0;
    step(1);
    check("k5_rst_level", key_level, 6'b000000);
    check("k5_rst_press", key_press, 6'b000000);
    check("k5_rst_evt",   key_evt,   6'b000000);
    check("k5_rst_long",  key_long,  1'b0);
    step(3);
    key_in = 6'b111111;
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(30);
    check("k5_post_evts",  evq.size(), 0);
    check("k5_post_level", n_lvl, 0);
    check("k5_post_press", n_press, 0);

    // Reset while a release of key 3 sits in the pending register.
    key_in = 6'b110111;
    step(20);
    check("k3_level", key_level, 6'b001000);
    key_in = 6'b111111;
    step(11);
    rst_n = 1'b0;
    step(1);
    check("k3_rst_evt", key_evt, 6'b000000);
    step(2);
    rst_n = 1'b1;
    clear_log();
    step(20);
    check("k3_post_evts", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Front-end for the six panel keys: synchronises and debounces the raw active-low `key_in` lines and turns them into single-cycle, one-hot navigation events for the menu/control FSM. It sits between the board pins and the top-level menu logic and replaces per-key release detection with a single arbitrated event bus. Optional auto-repeat on a held key lets the menu step parameters continuously.

## Interface
- `N_KEYS`, 6: number of key channels.
- `DEBOUNCE_CYC`, 1000: stable-sample cycles required to accept a level change (≥2).
- `REPEAT_DELAY`, 25_000_000: hold cycles before the first repeat (500 ms).
- `REPEAT_RATE`, 5_000_000: cycles between subsequent repeats (100 ms).
- `clk_50M` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low; clock clk_50M.
- `key_in` in N_KEYS: raw key pins, 0 = pressed, asynchronous.
- `key_level` out N_KEYS: debounced state, 1 = pressed; reset 0.
- `key_press` out N_KEYS: 1-cycle pulse per key on debounced press; reset 0.
- `key_evt` out N_KEYS: arbitrated one-hot event pulse (release or repeat); reset 0.
- `key_long` out 1: a single key is held past REPEAT_DELAY; reset 0.

## Operation
- Sync: 2-flop synchroniser per key, reset value 1 (released).
- Debounce per key: counter clears whenever the synced sample equals the stable state; increments while it differs; on reaching DEBOUNCE_CYC-1 the stable state flips and the counter clears. Glitches shorter than DEBOUNCE_CYC never propagate.
- `key_level` = inverted stable state. `key_press[i]` pulses on stable 1→0.
- Event sources, per key: release (stable 0→1) and repeat tick. Sources set `pend[i]`.
- Release of a key that produced ≥1 repeat sets no pend bit (hold emits repeats only).
- Arbiter: each cycle the lowest-index set `pend` bit is emitted on `key_evt` and cleared; at most one `key_evt` bit high per cycle. A new source for a key already pending merges (one emission).
- Repeat engine (shared): active only when exactly one `key_level` bit is set. Counter runs from that key's press; at REPEAT_DELAY a repeat tick fires, `key_long` sets, counter reloads for REPEAT_RATE periods. Zero or ≥2 keys held: counter cleared, `key_long` 0, no ticks. Key change (different single key) restarts from 0.
- Counter widths: `$clog2` of the largest count; no wrap, saturate at terminal value.

## Timing
- Raw edge → `key_level` change: 2 + DEBOUNCE_CYC cycles, input held stable.
- `key_level` change → `key_press`: same cycle as the level update (registered together).
- Source event → `pend` set: 1 cycle; `pend` → `key_evt`: 1 cycle if no lower-index pend bit, otherwise +1 cycle per lower-index pending bit.
- Simultaneous sources on several keys: all latched, emitted in ascending index order on consecutive cycles.
- Reset (any time): sync flops to 1, counters 0, `pend` 0, all outputs 0 on the next edge; an in-progress hold produces no event after reset.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: repeat engine and `key_long` as above.
- Undefined: no repeat logic; `key_long` tied 0; every release produces an event; REPEAT_* parameters unused.

## Structure
- Package `key_pkg`: key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_UP=2, KEY_DOWN=3, KEY_CONFIRM=4, KEY_QUIT=5; default timing constants for 50 MHz.
- Sub-module `key_debounce_ch`: one synchroniser + debounce counter + press/release edge detect, instantiated N_KEYS times; arbiter and repeat engine stay in the top.

## Test plan
(Bench params: DEBOUNCE_CYC=8, REPEAT_DELAY=100, REPEAT_RATE=20.)
- key_in[0] low 4 cycles then high → no `key_level`, `key_press`, or `key_evt` activity.
- key_in[4] low 50 cycles then high → `key_press[4]` pulse 10 cycles after fall; `key_evt`=6'b010000 once, 12 cycles after rise.
- key_in[1] and key_in[3] released same cycle → `key_evt` 6'b000010 then 6'b001000 on consecutive cycles.
- With macro, key_in[2] low 200 cycles → repeats at 100, 120, 140, 160, 180 cycles after `key_level[2]` rises; `key_long`=1 from first repeat; no release event.
- With macro, keys 0 and 1 held 200 cycles → no repeats, `key_long`=0; two release events on release.
- rst_n low mid-hold of key 5 (after 60 cycles), then released → all outputs 0, no `key_evt` after reset.
